// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32x32 multiply / 32/32 divide unit with HI/LO result registers.
//
// Ports:
//   in_clk   - clock; all state changes on the rising edge
//   clr      - synchronous active-high reset
//   in_start - begin the operation selected by in_op (sampled only while idle)
//   in_op    - 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   in_PA    - operand A (multiplicand / dividend), also MTHI/MTLO data
//   in_PB    - operand B (multiplier / divisor)
//   in_mthi  - write in_PA into HI (idle only, loses to in_start)
//   in_mtlo  - write in_PA into LO (idle only, loses to in_start)
//   out_HI   - product high word / remainder
//   out_LO   - product low word / quotient
//   out_busy - operation in progress (RUN or FIX)
//   out_done - one-cycle pulse after HI/LO take a new result
module mult_div_unit (
    input  logic        in_clk,
    input  logic        clr,
    input  logic        in_start,
    input  logic [1:0]  in_op,
    input  logic [31:0] in_PA,
    input  logic [31:0] in_PB,
    input  logic        in_mthi,
    input  logic        in_mtlo,
    output logic [31:0] out_HI,
    output logic [31:0] out_LO,
    output logic        out_busy,
    output logic        out_done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    logic [1:0]  state_q;
    logic [5:0]  cnt_q;
    logic [1:0]  op_q;
    logic        neg_q;   // result (product / quotient) must be negated
    logic        rneg_q;  // remainder must be negated (signed divide, negative dividend)
    logic [31:0] m_q;     // |multiplicand| for multiply, |divisor| for divide
    logic [31:0] hw_q;    // working high word: partial product / partial remainder
    logic [31:0] lw_q;    // working low word: multiplier bits / dividend->quotient bits
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        done_q;

    // Operand preparation at start
    logic        st_signed;
    logic [31:0] abs_a;
    logic [31:0] abs_b;

    // One iteration and final correction
    logic [32:0] mul_sum;
    logic [32:0] div_trial;
    logic [32:0] div_diff;
    logic        div_bit;
    logic [31:0] step_hw;
    logic [31:0] step_lw;
    logic [63:0] prod;
    logic [31:0] fix_hi;
    logic [31:0] fix_lo;

    always_comb begin
        st_signed = in_op[0];
        abs_a = (st_signed && in_PA[31]) ? -in_PA : in_PA;
        abs_b = (st_signed && in_PB[31]) ? -in_PB : in_PB;

        // Shift-add: add multiplicand when the current multiplier LSB is set, then shift the
        // 65-bit {carry, hw, lw} right by one.
        mul_sum = {1'b0, hw_q} + (lw_q[0] ? {1'b0, m_q} : 33'd0);

        // Restoring divide: shift next dividend bit into the remainder, subtract if it fits.
        div_trial = {hw_q, lw_q[31]};
        div_diff  = div_trial - {1'b0, m_q};
        div_bit   = (div_trial >= {1'b0, m_q});

        if (op_q[1]) begin
            step_hw = div_bit ? div_diff[31:0] : div_trial[31:0];
            step_lw = {lw_q[30:0], div_bit};
        end else begin
            step_hw = mul_sum[32:1];
            step_lw = {mul_sum[0], lw_q[31:1]};
        end

        prod = {hw_q, lw_q};
        if (neg_q) begin
            prod = -prod;
        end

        if (op_q[1]) begin
            fix_hi = rneg_q ? -hw_q : hw_q;
            // Divide by zero leaves all-ones quotient bits; keep them unsigned-corrected so
            // LO is 0xFFFFFFFF for DIV as well, while HI (remainder) restores the dividend.
            if (m_q == 32'd0) begin
                fix_lo = 32'hFFFF_FFFF;
            end else begin
                fix_lo = neg_q ? -lw_q : lw_q;
            end
        end else begin
            fix_hi = prod[63:32];
            fix_lo = prod[31:0];
        end
    end

    always_ff @(posedge in_clk) begin
        if (clr) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
            op_q    <= 2'd0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            m_q     <= 32'd0;
            hw_q    <= 32'd0;
            lw_q    <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_start) begin
                        state_q <= RUN;
                        cnt_q   <= 6'd0;
                        op_q    <= in_op;
                        neg_q   <= st_signed && (in_PA[31] ^ in_PB[31]);
                        rneg_q  <= st_signed && in_PA[31];
                        m_q     <= in_op[1] ? abs_b : abs_a;
                        hw_q    <= 32'd0;
                        lw_q    <= in_op[1] ? abs_a : abs_b;
                    end else begin
                        if (in_mthi) begin
                            hi_q <= in_PA;
                        end
                        if (in_mtlo) begin
                            lo_q <= in_PA;
                        end
                    end
                end
                RUN: begin
                    hw_q  <= step_hw;
                    lw_q  <= step_lw;
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    hi_q    <= fix_hi;
                    lo_q    <= fix_lo;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign out_HI   = hi_q;
    assign out_LO   = lo_q;
    assign out_busy = (state_q != IDLE);
    assign out_done = done_q;

endmodule
